// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA frame-buffer path.
// Display timing is 640x480@60; the frame buffer is the 4x-downscaled 160x120 image.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned V_BACK   = 33;

  localparam int unsigned SCR_W       = 11;
  localparam int unsigned FB_W        = 160;
  localparam int unsigned FB_H        = 120;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned FB_WORDS    = 19200;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a screen coordinate to a linear frame-buffer word address.
// For the 160-word line the multiply is folded into (y<<7)+(y<<5) so no multiplier is inferred.
module fb_addr_gen #(
  parameter int unsigned ADDR_W      = vga_pkg::ADDR_W_DEF,
  parameter int unsigned FB_W        = vga_pkg::FB_W,
  parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
  input  logic [vga_pkg::SCR_W-1:0] x,
  input  logic [vga_pkg::SCR_W-1:0] y,
  output logic [ADDR_W-1:0]         addr_c
);
  import vga_pkg::*;

  logic [SCR_W-1:0] x_fb;
  logic [SCR_W-1:0] y_fb;

  always_comb begin
    x_fb = x >> SCALE_SHIFT;
    y_fb = y >> SCALE_SHIFT;
  end

  generate
    if (FB_W == 160) begin : g_shift_add
      always_comb begin
        addr_c = ADDR_W'({y_fb, 7'd0}) + ADDR_W'({y_fb, 5'd0}) + ADDR_W'(x_fb);
      end
    end else begin : g_mult
      always_comb begin
        addr_c = ADDR_W'(32'(y_fb) * 32'(FB_W)) + ADDR_W'(x_fb);
      end
    end
  endgenerate

endmodule

// File: rtl/vga_frame_arbiter.sv
// Single-port frame RAM arbiter: display fetch owns the port during active video,
// host writes are squeezed into blanking cycles with a req/ack handshake.
module vga_frame_arbiter #(
  parameter int unsigned DATA_W      = vga_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W      = vga_pkg::ADDR_W_DEF,
  parameter int unsigned FB_W        = vga_pkg::FB_W,
  parameter int unsigned FB_H        = vga_pkg::FB_H,
  parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Ready_Sig,
  input  logic [10:0]       Column_Addr_Sig,
  input  logic [10:0]       Row_Addr_Sig,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ack,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  output logic              Mem_We,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic [DATA_W-1:0] Pixel_Data,
  output logic              Pixel_Valid,
  output logic              Err_Sig
);
  import vga_pkg::*;

  localparam int unsigned WORDS = FB_W * FB_H;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ADDR_W-1:0] disp_addr_c;
  logic              wr_in_range_c;
  logic              disp_v1;

  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt;
  logic              ack_nxt;
  logic              err_nxt;

  fb_addr_gen #(
    .ADDR_W     (ADDR_W),
    .FB_W       (FB_W),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_addr_gen (
    .x     (Column_Addr_Sig),
    .y     (Row_Addr_Sig),
    .addr_c(disp_addr_c)
  );

  always_comb begin
    wr_in_range_c = (Wr_Addr < ADDR_W'(WORDS));
  end

  // Port owner for the next cycle; a write is never granted twice in a row so the
  // writer has a cycle to see Wr_Ack and retire its request.
  always_comb begin
    state_nxt = IDLE;
    addr_nxt  = Mem_Addr;
    wdata_nxt = Mem_Wdata;
    we_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = Err_Sig;

    if (Ready_Sig) begin
      state_nxt = DISP;
    end else if (Wr_Req && (state != WRITE)) begin
      state_nxt = WRITE;
    end

    case (state_nxt)
      DISP: begin
        addr_nxt = disp_addr_c;
      end
      WRITE: begin
        ack_nxt = 1'b1;
        if (wr_in_range_c) begin
          addr_nxt  = Wr_Addr;
          wdata_nxt = Wr_Data;
          we_nxt    = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      Mem_Addr    <= '0;
      Mem_Wdata   <= '0;
      Mem_We      <= 1'b0;
      Wr_Ack      <= 1'b0;
      Err_Sig     <= 1'b0;
      disp_v1     <= 1'b0;
      Pixel_Valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      Mem_Addr    <= addr_nxt;
      Mem_Wdata   <= wdata_nxt;
      Mem_We      <= we_nxt;
      Wr_Ack      <= ack_nxt;
      Err_Sig     <= err_nxt;
      disp_v1     <= Ready_Sig;
      Pixel_Valid <= disp_v1;
    end
  end

  // The RAM's own output register supplies the pixel; only gate it to zero outside active video.
  always_comb begin
    Pixel_Data = Pixel_Valid ? Mem_Rdata : '0;
  end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Directed and randomized checks of the frame RAM arbiter against a cycle-level reference model.
module tb_vga_frame_arbiter;

  logic        CLK;
  logic        RST;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [10:0] Row_Addr_Sig;
  logic        Wr_Req;
  logic [14:0] Wr_Addr;
  logic [7:0]  Wr_Data;
  logic        Wr_Ack;
  logic [14:0] Mem_Addr;
  logic [7:0]  Mem_Wdata;
  logic        Mem_We;
  logic [7:0]  Mem_Rdata;
  logic [7:0]  Pixel_Data;
  logic        Pixel_Valid;
  logic        Err_Sig;

  int total;
  int bad;

  vga_frame_arbiter dut (
    .CLK            (CLK),
    .RST            (RST),
    .Ready_Sig      (Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig),
    .Row_Addr_Sig   (Row_Addr_Sig),
    .Wr_Req         (Wr_Req),
    .Wr_Addr        (Wr_Addr),
    .Wr_Data        (Wr_Data),
    .Wr_Ack         (Wr_Ack),
    .Mem_Addr       (Mem_Addr),
    .Mem_Wdata      (Mem_Wdata),
    .Mem_We         (Mem_We),
    .Mem_Rdata      (Mem_Rdata),
    .Pixel_Data     (Pixel_Data),
    .Pixel_Valid    (Pixel_Valid),
    .Err_Sig        (Err_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle; registered outputs now show the previous cycle's decision.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] m_addr, m_wdata, n_addr, n_wdata, wa, wd;
    bit          m_err, n_err, n_we, n_ack, n_pv, g_prev, r_prev, rdy, req_on;
    int unsigned run_left;

    total = 0;
    bad   = 0;
    RST = 1'b1; Ready_Sig = 1'b0; Column_Addr_Sig = '0; Row_Addr_Sig = '0;
    Wr_Req = 1'b1; Wr_Addr = 15'd5; Wr_Data = 8'h11; Mem_Rdata = 8'h00;

    // reset held 3 cycles with a pending request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ack", 32'(Wr_Ack), 32'd0);
      chk("rst_we", 32'(Mem_We), 32'd0);
    end
    chk("rst_pv", 32'(Pixel_Valid), 32'd0);
    chk("rst_err", 32'(Err_Sig), 32'd0);
    chk("rst_pdata", 32'(Pixel_Data), 32'd0);
    RST = 1'b0;
    tick();
    chk("post_rst_ack", 32'(Wr_Ack), 32'd1);
    chk("post_rst_we", 32'(Mem_We), 32'd1);
    chk("post_rst_addr", 32'(Mem_Addr), 32'd5);
    Wr_Req = 1'b0;
    tick();
    chk("post_rst_ack_drop", 32'(Wr_Ack), 32'd0);

    // address map and display latency
    Ready_Sig = 1'b1; Column_Addr_Sig = 11'd4; Row_Addr_Sig = 11'd8;
    tick();
    chk("map_addr_321", 32'(Mem_Addr), 32'd321);
    chk("map_we", 32'(Mem_We), 32'd0);
    chk("map_pv_early", 32'(Pixel_Valid), 32'd0);
    Column_Addr_Sig = 11'd639; Row_Addr_Sig = 11'd479;
    tick();
    chk("map_addr_max", 32'(Mem_Addr), 32'd19199);
    Mem_Rdata = 8'hA5;
    #1;
    chk("pix_data_a5", 32'(Pixel_Data), 32'hA5);
    chk("pix_valid", 32'(Pixel_Valid), 32'd1);
    Ready_Sig = 1'b0;
    tick();
    Mem_Rdata = 8'h5A;
    #1;
    chk("pix_data_5a", 32'(Pixel_Data), 32'h5A);
    tick();
    chk("pix_valid_off", 32'(Pixel_Valid), 32'd0);
    chk("pix_data_off", 32'(Pixel_Data), 32'd0);
    chk("idle_addr_hold", 32'(Mem_Addr), 32'd19199);

    // blanking writes, second held request
    Wr_Req = 1'b1; Wr_Addr = 15'd100; Wr_Data = 8'h3C;
    tick();
    chk("wr_we", 32'(Mem_We), 32'd1);
    chk("wr_addr", 32'(Mem_Addr), 32'd100);
    chk("wr_data", 32'(Mem_Wdata), 32'h3C);
    chk("wr_ack", 32'(Wr_Ack), 32'd1);
    Wr_Addr = 15'd101; Wr_Data = 8'h3D;
    tick();
    chk("wr2_gap_ack", 32'(Wr_Ack), 32'd0);
    chk("wr2_gap_we", 32'(Mem_We), 32'd0);
    chk("wdata_hold", 32'(Mem_Wdata), 32'h3C);
    tick();
    chk("wr2_ack", 32'(Wr_Ack), 32'd1);
    chk("wr2_addr", 32'(Mem_Addr), 32'd101);
    chk("wr2_data", 32'(Mem_Wdata), 32'h3D);
    Wr_Req = 1'b0;
    tick();

    // display priority over a pending write
    Ready_Sig = 1'b1; Column_Addr_Sig = 11'd0; Row_Addr_Sig = 11'd0;
    Wr_Req = 1'b1; Wr_Addr = 15'd200; Wr_Data = 8'h77;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("prio_ack", 32'(Wr_Ack), 32'd0);
      chk("prio_we", 32'(Mem_We), 32'd0);
    end
    Ready_Sig = 1'b0;
    tick();
    chk("prio_fall_ack", 32'(Wr_Ack), 32'd1);
    chk("prio_fall_we", 32'(Mem_We), 32'd1);
    chk("prio_fall_addr", 32'(Mem_Addr), 32'd200);
    Wr_Req = 1'b0;
    tick();

    // out-of-range write
    Wr_Req = 1'b1; Wr_Addr = 15'd19200; Wr_Data = 8'h99;
    tick();
    chk("oor_ack", 32'(Wr_Ack), 32'd1);
    chk("oor_we", 32'(Mem_We), 32'd0);
    chk("oor_err", 32'(Err_Sig), 32'd1);
    Wr_Req = 1'b0;
    tick();
    chk("err_held", 32'(Err_Sig), 32'd1);
    Wr_Req = 1'b1; Wr_Addr = 15'd7; Wr_Data = 8'h42;
    tick();
    chk("after_oor_we", 32'(Mem_We), 32'd1);
    chk("after_oor_addr", 32'(Mem_Addr), 32'd7);
    chk("after_oor_err", 32'(Err_Sig), 32'd1);
    Wr_Req = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk("err_cleared", 32'(Err_Sig), 32'd0);
    RST = 1'b0;
    tick();

    // reset in the cycle a write would be decided
    Wr_Req = 1'b1; Wr_Addr = 15'd9; Wr_Data = 8'h01; RST = 1'b1;
    tick();
    chk("midrst_we", 32'(Mem_We), 32'd0);
    chk("midrst_ack", 32'(Wr_Ack), 32'd0);
    RST = 1'b0;
    tick();
    chk("midrst_retry_ack", 32'(Wr_Ack), 32'd1);
    Wr_Req = 1'b0;
    tick();

    // randomized traffic against the reference model
    m_addr = '0; m_wdata = '0; m_err = 1'b0; g_prev = 1'b0; r_prev = 1'b0;
    rdy = 1'b0; req_on = 1'b0; run_left = 0; wa = '0; wd = '0;
    for (int c = 0; c < 2500; c++) begin
      bit          rst_c, grant, inr;
      int unsigned col_c, row_c;
      logic [7:0]  rd;
      rst_c = (c == 0) || ($urandom_range(0, 199) == 0);
      if (run_left == 0) begin
        rdy      = !rdy;
        run_left = $urandom_range(1, 24);
      end
      run_left--;
      col_c = $urandom_range(0, 639);
      row_c = $urandom_range(0, 479);
      if (!req_on && ($urandom_range(0, 2) == 0)) begin
        req_on = 1'b1;
        wa = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(19200, 32767))
                                          : 32'($urandom_range(0, 19199));
        wd = 32'($urandom_range(0, 255));
      end
      RST = rst_c; Ready_Sig = rdy;
      Column_Addr_Sig = 11'(col_c); Row_Addr_Sig = 11'(row_c);
      Wr_Req = req_on; Wr_Addr = 15'(wa); Wr_Data = 8'(wd);

      grant = !rst_c && !rdy && req_on && !g_prev;
      inr   = (wa < 32'd19200);
      if (rst_c) begin
        n_addr = '0; n_wdata = '0; n_err = 1'b0; n_we = 1'b0; n_ack = 1'b0; n_pv = 1'b0;
      end else begin
        if (rdy)               n_addr = 32'((row_c / 4) * 160 + (col_c / 4));
        else if (grant && inr) n_addr = wa;
        else                   n_addr = m_addr;
        n_wdata = (grant && inr) ? wd : m_wdata;
        n_we    = grant && inr;
        n_ack   = grant;
        n_err   = m_err || (grant && !inr);
        n_pv    = r_prev;
      end
      g_prev = grant;
      r_prev = rdy && !rst_c;
      m_addr = n_addr; m_wdata = n_wdata; m_err = n_err;
      if (n_ack) req_on = 1'b0;

      tick();
      rd = 8'($urandom_range(0, 255));
      Mem_Rdata = rd;
      #1;
      chk("rnd_addr", 32'(Mem_Addr), n_addr);
      chk("rnd_wdata", 32'(Mem_Wdata), n_wdata);
      chk("rnd_we", 32'(Mem_We), 32'(n_we));
      chk("rnd_ack", 32'(Wr_Ack), 32'(n_ack));
      chk("rnd_err", 32'(Err_Sig), 32'(n_err));
      chk("rnd_pv", 32'(Pixel_Valid), 32'(n_pv));
      chk("rnd_pdata", 32'(Pixel_Data), n_pv ? 32'(rd) : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
